// File: rtl/ecc_hamming_encoder_pipe.sv
// SECDED Hamming encoder (32 data + 6 parity + 1 overall parity) with a
// 2-stage valid/ready pipeline, one-shot error injection and a saturating
// count of words delivered on the output port.
module ecc_hamming_encoder_pipe #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned PARITY_LENGTH = 6,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [PARITY_LENGTH-1:0] out_parity,
  output logic                     out_oe_parity,
  input  logic                     inj_req,
  input  logic [1:0]               inj_mode,
  input  logic [5:0]               inj_pos0,
  input  logic [5:0]               inj_pos1,
  output logic                     inj_armed,
  output logic [CNT_WIDTH-1:0]     word_cnt
);

  localparam int unsigned CW_WIDTH  = DATA_WIDTH + PARITY_LENGTH;
  localparam int unsigned POS_WIDTH = 6;
  localparam int unsigned POS_OE    = CW_WIDTH;
  localparam logic [1:0]  MODE_SINGLE = 2'b01;
  localparam logic [1:0]  MODE_DOUBLE = 2'b10;

  // Scatter data bits into the non-power-of-two Hamming positions.
  function automatic logic [CW_WIDTH-1:0] place_data(input logic [DATA_WIDTH-1:0] d);
    logic [CW_WIDTH-1:0] cw;
    int unsigned         j;
    cw = '0;
    j  = 0;
    for (int unsigned i = 0; i < CW_WIDTH; i++) begin
      if (((i + 1) & i) != 0) begin
        cw[i] = d[j];
        j++;
      end
    end
    return cw;
  endfunction

  // Gather data bits back out of a codeword.
  function automatic logic [DATA_WIDTH-1:0] extract_data(input logic [CW_WIDTH-1:0] cw);
    logic [DATA_WIDTH-1:0] d;
    int unsigned           j;
    d = '0;
    j = 0;
    for (int unsigned i = 0; i < CW_WIDTH; i++) begin
      if (((i + 1) & i) != 0) begin
        d[j] = cw[i];
        j++;
      end
    end
    return d;
  endfunction

  // p_k covers every position whose 1-based index has bit k set.
  function automatic logic [PARITY_LENGTH-1:0] calc_parity(input logic [CW_WIDTH-1:0] cw);
    logic [PARITY_LENGTH-1:0] p;
    p = '0;
    for (int unsigned k = 0; k < PARITY_LENGTH; k++) begin
      for (int unsigned i = 0; i < CW_WIDTH; i++) begin
        if ((((i + 1) >> k) & 1) != 0) p[k] = p[k] ^ cw[i];
      end
    end
    return p;
  endfunction

  // Merge parity bits into their power-of-two positions.
  function automatic logic [CW_WIDTH-1:0] build_cw(input logic [DATA_WIDTH-1:0] d,
                                                   input logic [PARITY_LENGTH-1:0] p);
    logic [CW_WIDTH-1:0] cw;
    cw = place_data(d);
    for (int unsigned k = 0; k < PARITY_LENGTH; k++) cw[(1 << k) - 1] = p[k];
    return cw;
  endfunction

  function automatic logic [PARITY_LENGTH-1:0] extract_parity(input logic [CW_WIDTH-1:0] cw);
    logic [PARITY_LENGTH-1:0] p;
    for (int unsigned k = 0; k < PARITY_LENGTH; k++) p[k] = cw[(1 << k) - 1];
    return p;
  endfunction

  logic                     s1_valid;
  logic [DATA_WIDTH-1:0]    s1_data;
  logic [PARITY_LENGTH-1:0] s1_parity;

  logic                     inj_double_q;
  logic [POS_WIDTH-1:0]     inj_pos0_q;
  logic [POS_WIDTH-1:0]     inj_pos1_q;

  logic                     s2_adv_c;
  logic                     load_s2_c;
  logic                     arm_c;
  logic                     oe_c;
  logic [CW_WIDTH:0]        flip_c;
  logic [CW_WIDTH:0]        cw_flipped_c;

  // Stage 2 moves whenever its output slot is empty or being drained.
  assign s2_adv_c  = !out_valid || out_ready;
  assign load_s2_c = s2_adv_c && s1_valid;
  assign in_ready  = !s1_valid || s2_adv_c;

  // Accept a request only if nothing is pending and every used position is in range.
  assign arm_c = inj_req &&
                 (((inj_mode == MODE_SINGLE) && (inj_pos0 <= POS_WIDTH'(POS_OE))) ||
                  ((inj_mode == MODE_DOUBLE) && (inj_pos0 <= POS_WIDTH'(POS_OE)) &&
                   (inj_pos1 <= POS_WIDTH'(POS_OE))));

  // Build the full 39-bit word from stage 1 and apply the armed flip mask.
  always_comb begin
    flip_c = '0;
    oe_c   = ^{s1_data, s1_parity};
    if (inj_armed) begin
      for (int unsigned i = 0; i <= POS_OE; i++) begin
        if (inj_pos0_q == POS_WIDTH'(i)) flip_c[i] = 1'b1;
        if (inj_double_q && (inj_pos1_q == POS_WIDTH'(i))) flip_c[i] = flip_c[i] ^ 1'b1;
      end
    end
    cw_flipped_c = {oe_c, build_cw(s1_data, s1_parity)} ^ flip_c;
  end

  // Stage 1: capture the raw word and its Hamming parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_parity <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data   <= in_data;
        s1_parity <= calc_parity(place_data(in_data));
      end
    end
  end

  // Stage 2: output register, holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_parity    <= '0;
      out_oe_parity <= 1'b0;
    end else if (s2_adv_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data      <= extract_data(cw_flipped_c[CW_WIDTH-1:0]);
        out_parity    <= extract_parity(cw_flipped_c[CW_WIDTH-1:0]);
        out_oe_parity <= cw_flipped_c[CW_WIDTH];
      end
    end
  end

  // Injection arm/consume; a request is only seen when nothing was pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_armed    <= 1'b0;
      inj_double_q <= 1'b0;
      inj_pos0_q   <= '0;
      inj_pos1_q   <= '0;
    end else if (inj_armed) begin
      if (load_s2_c) inj_armed <= 1'b0;
    end else if (arm_c) begin
      inj_armed    <= 1'b1;
      inj_double_q <= (inj_mode == MODE_DOUBLE);
      inj_pos0_q   <= inj_pos0;
      inj_pos1_q   <= inj_pos1;
    end
  end

  // Saturating count of output handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (out_valid && out_ready && (word_cnt != {CNT_WIDTH{1'b1}})) begin
      word_cnt <= word_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_ecc_hamming_encoder_pipe.sv
// Directed and randomized-stall bench for the SECDED encoder pipeline.
module tb_ecc_hamming_encoder_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_parity;
  logic        out_oe_parity;
  logic        inj_req;
  logic [1:0]  inj_mode;
  logic [5:0]  inj_pos0;
  logic [5:0]  inj_pos1;
  logic        inj_armed;
  logic [15:0] word_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  ecc_hamming_encoder_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_parity(out_parity), .out_oe_parity(out_oe_parity),
    .inj_req(inj_req), .inj_mode(inj_mode), .inj_pos0(inj_pos0), .inj_pos1(inj_pos1),
    .inj_armed(inj_armed), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reassemble the 39-bit word from the output fields using the documented layout.
  function automatic logic [38:0] assemble(input logic [31:0] d, input logic [5:0] p, input logic oe);
    logic [38:0] c;
    c[0] = p[0]; c[1] = p[1]; c[2] = d[0]; c[3] = p[2];
    c[6:4] = d[3:1]; c[7] = p[3]; c[14:8] = d[10:4]; c[15] = p[4];
    c[30:16] = d[25:11]; c[31] = p[5]; c[37:32] = d[31:26]; c[38] = oe;
    return c;
  endfunction

  function automatic logic [5:0] syndrome(input logic [38:0] c);
    logic [5:0] s;
    s = '0;
    for (int i = 0; i < 38; i++) if (c[i]) s = s ^ 6'(i + 1);
    return s;
  endfunction

  // 1 = clean, 2 = single (correctable), 3 = double detected.
  function automatic int decode_label(input logic [38:0] c);
    if (^c) return 2;
    if (syndrome(c) != 6'd0) return 3;
    return 1;
  endfunction

  function automatic logic [31:0] corrected_data(input logic [38:0] c);
    logic [38:0] f;
    logic [5:0]  s;
    f = c;
    s = syndrome(c);
    if (s != 6'd0 && s <= 6'd38) f[s - 6'd1] = ~f[s - 6'd1];
    return {f[37:32], f[30:16], f[14:8], f[6:4], f[2]};
  endfunction

  task automatic encode_check(input string tag, input logic [31:0] d, input logic [31:0] ed,
                              input logic [5:0] ep, input logic eoe);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_lat1"}, 64'(out_valid), 64'(1'b0));
    @(posedge clk); #1;
    check({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
    check({tag, "_data"}, 64'(out_data), 64'(ed));
    check({tag, "_par"}, 64'(out_parity), 64'(ep));
    check({tag, "_oe"}, 64'(out_oe_parity), 64'(eoe));
  endtask

  task automatic arm(input logic [1:0] m, input logic [5:0] a, input logic [5:0] b);
    @(negedge clk);
    inj_req  = 1'b1;
    inj_mode = m;
    inj_pos0 = a;
    inj_pos1 = b;
    @(posedge clk); #1;
    inj_req = 1'b0;
  endtask

  logic [38:0] cw;
  logic [31:0] exp_d;
  logic [31:0] q[$];
  int          sent;
  int          rcvd;
  bit          acc;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    inj_req = 1'b0; inj_mode = 2'b00; inj_pos0 = '0; inj_pos1 = '0;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'(1'b0));
    check("rst_out_data", 64'(out_data), 64'(32'h0));
    check("rst_out_par", 64'(out_parity), 64'(6'h0));
    check("rst_out_oe", 64'(out_oe_parity), 64'(1'b0));
    check("rst_armed", 64'(inj_armed), 64'(1'b0));
    check("rst_cnt", 64'(word_cnt), 64'(16'h0));
    @(negedge clk); rst_n = 1'b1;
    #1 check("rst_in_ready", 64'(in_ready), 64'(1'b1));

    // Plain encodes (hand-computed parity/oe).
    encode_check("zero", 32'h0, 32'h0, 6'b000000, 1'b0);
    encode_check("one", 32'h1, 32'h1, 6'b000011, 1'b1);
    encode_check("ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 6'b011000, 1'b0);
    encode_check("msb", 32'h80000000, 32'h80000000, 6'b100110, 1'b0);
    check("msb_label", 64'(decode_label(assemble(out_data, out_parity, out_oe_parity))), 64'(1));

    // Requests that must be ignored.
    arm(2'b00, 6'd2, 6'd0);
    check("ign_mode00", 64'(inj_armed), 64'(1'b0));
    arm(2'b11, 6'd2, 6'd3);
    check("ign_mode11", 64'(inj_armed), 64'(1'b0));
    arm(2'b01, 6'd39, 6'd0);
    check("ign_pos39", 64'(inj_armed), 64'(1'b0));

    // Single flip on data bit 0.
    arm(2'b01, 6'd2, 6'd0);
    check("single_armed", 64'(inj_armed), 64'(1'b1));
    encode_check("single", 32'h0, 32'h1, 6'b000000, 1'b0);
    check("single_disarm", 64'(inj_armed), 64'(1'b0));
    cw = assemble(out_data, out_parity, out_oe_parity);
    check("single_label", 64'(decode_label(cw)), 64'(2));
    check("single_corr", 64'(corrected_data(cw)), 64'(32'h0));

    // Double flip: data bit 0 plus the overall parity bit.
    arm(2'b10, 6'd2, 6'd38);
    encode_check("double", 32'hFFFFFFFF, 32'hFFFFFFFE, 6'b011000, 1'b1);
    check("double_label", 64'(decode_label(assemble(out_data, out_parity, out_oe_parity))), 64'(3));

    // Second request while armed is dropped; first positions stay.
    arm(2'b01, 6'd0, 6'd0);
    arm(2'b01, 6'd5, 6'd0);
    check("rearm_armed", 64'(inj_armed), 64'(1'b1));
    encode_check("rearm", 32'h0, 32'h0, 6'b000001, 1'b0);

    // Request on the consuming edge with nothing armed: word clean, next word flipped.
    @(negedge clk); in_valid = 1'b1; in_data = 32'h0;
    @(posedge clk); #1; in_valid = 1'b0;
    arm(2'b01, 6'd0, 6'd0);
    check("same_edge_armed", 64'(inj_armed), 64'(1'b1));
    check("same_edge_par", 64'(out_parity), 64'(6'b000000));
    encode_check("after_edge", 32'h0, 32'h0, 6'b000001, 1'b0);
    repeat (2) @(posedge clk);
    #1 check("dir_cnt", 64'(word_cnt), 64'(16'd9));

    // Stall: output held, later inputs ignored, then reset mid-stall.
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_data = 32'h1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); in_valid = 1'b1; in_data = 32'hFFFFFFFF;
    inj_req = 1'b1; inj_mode = 2'b01; inj_pos0 = 6'd5;
    @(posedge clk); #1; in_valid = 1'b0; inj_req = 1'b0;
    @(negedge clk); in_data = 32'h12345678;
    @(posedge clk); #1;
    check("stall_in_ready", 64'(in_ready), 64'(1'b0));
    check("stall_valid", 64'(out_valid), 64'(1'b1));
    check("stall_data", 64'(out_data), 64'(32'h1));
    check("stall_par", 64'(out_parity), 64'(6'b000011));
    check("stall_oe", 64'(out_oe_parity), 64'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'(1'b0));
    check("mid_rst_data", 64'(out_data), 64'(32'h0));
    check("mid_rst_par", 64'(out_parity), 64'(6'h0));
    check("mid_rst_oe", 64'(out_oe_parity), 64'(1'b0));
    check("mid_rst_armed", 64'(inj_armed), 64'(1'b0));
    check("mid_rst_cnt", 64'(word_cnt), 64'(16'h0));
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    #1 check("post_rst_ready", 64'(in_ready), 64'(1'b1));
    encode_check("post_rst", 32'h1, 32'h1, 6'b000011, 1'b1);

    // Random stream with random back-pressure, from a clean reset.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 3000 && rcvd < 100; cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < 100) begin
        in_valid = 1'b1;
        in_data  = $urandom;
      end
      #4;
      acc = 1'b0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rnd_extra", 64'(1), 64'(0));
        end else begin
          exp_d = q.pop_front();
          check("rnd_data", 64'(out_data), 64'(exp_d));
          check("rnd_label", 64'(decode_label(assemble(out_data, out_parity, out_oe_parity))), 64'(1));
        end
        rcvd++;
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        sent++;
        acc = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    check("rnd_rcvd", 64'(rcvd), 64'(100));
    check("rnd_cnt", 64'(word_cnt), 64'(16'd100));
    check("rnd_q_empty", 64'(q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
